// File: rtl/lsu_align.sv
// Load/store alignment unit in front of the 4 KB data memory (dm_4k).
// Turns byte/half/word requests into word-addressed memory cycles with byte-lane
// enables, and splits accesses that straddle a word boundary into two cycles.
// Define LSU_MISALIGN_TRAP_EN to make misaligned half/word requests return
// rsp_err=1 with no memory access, instead of being split.
module lsu_align #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-3:0] dm_addr,
    output logic [31:0]       dm_din,
    output logic              dm_we,
    output logic [3:0]        dm_wbit,
    input  logic [31:0]       dm_dout
);

    localparam int unsigned WA = ADDR_W - 2;
    localparam logic [WA-1:0] AddrOne = WA'(1);

    typedef enum logic [1:0] {StIdle, StAcc1, StAcc2, StRsp} state_e;

    // Byte count for a size code; the reserved code behaves as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // cnt consecutive lanes starting at lane start, clipped to the word.
    function automatic logic [3:0] lane_mask(input logic [1:0] start, input logic [2:0] cnt);
        logic [4:0] m;
        logic [7:0] s;
        m = (5'd1 << cnt) - 5'd1;
        s = {3'b000, m} << start;
        return s[3:0];
    endfunction

    // Keep the low cnt bytes of d, zero the rest.
    function automatic logic [31:0] keep_bytes(input logic [31:0] d, input logic [2:0] cnt);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = (i < int'(cnt)) ? d[8*i +: 8] : 8'h00;
        end
        return r;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] n,
                                           input logic sgn);
        case (n)
            3'd1:    return {{24{sgn & d[7]}}, d[7:0]};
            3'd2:    return {{16{sgn & d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    state_e state_q, state_d;

    // Request context held for the duration of the access.
    logic        we_q, we_d;
    logic        sgn_q, sgn_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  n_q, n_d;
    logic [2:0]  k1_q, k1_d;
    logic        split_q, split_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] part_q, part_d;

    logic [WA-1:0] dm_addr_q, dm_addr_d;
    logic [31:0]   dm_din_q, dm_din_d;
    logic          dm_we_q, dm_we_d;
    logic [3:0]    dm_wbit_q, dm_wbit_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic [1:0]  req_off;
    logic [2:0]  req_n;
    logic [2:0]  req_room;
    logic [2:0]  req_k1;
    logic        req_split;
    logic        req_trap;
    logic        accept;
    logic [2:0]  k2;
    logic [31:0] acc1_bytes;
    logic [31:0] acc2_bytes;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_W];

    assign req_off   = req_addr[1:0];
    assign req_n     = size_bytes(req_size);
    assign req_room  = 3'd4 - {1'b0, req_off};
    // Bytes that fit in the first word; the rest go to the next word.
    assign req_k1    = (req_n > req_room) ? req_room : req_n;
    assign req_split = (req_n != req_k1);
    assign req_ready = (state_q == StIdle);
    assign accept    = req_valid && req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_trap = ((req_size == 2'b01) && req_off[0]) || (req_size[1] && (req_off != 2'b00));
`else
    assign req_trap = 1'b0;
`endif

    // Lanes read in each access, already shifted into their final position.
    assign k2         = n_q - k1_q;
    assign acc1_bytes = keep_bytes(dm_dout >> {off_q, 3'b000}, k1_q);
    assign acc2_bytes = keep_bytes(dm_dout, k2) << {k1_q, 3'b000};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (accept) state_d = req_trap ? StRsp : StAcc1;
            StAcc1: state_d = split_q ? StAcc2 : StRsp;
            StAcc2: state_d = StRsp;
            StRsp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Next values for memory-side and response registers.
    always_comb begin
        we_d        = we_q;
        sgn_d       = sgn_q;
        off_d       = off_q;
        n_d         = n_q;
        k1_d        = k1_q;
        split_d     = split_q;
        wdata_d     = wdata_q;
        part_d      = part_q;
        dm_addr_d   = dm_addr_q;
        dm_din_d    = dm_din_q;
        dm_we_d     = 1'b0;
        dm_wbit_d   = 4'b0000;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    we_d    = req_we;
                    sgn_d   = req_signed;
                    off_d   = req_off;
                    n_d     = req_n;
                    k1_d    = req_k1;
                    split_d = req_split;
                    wdata_d = req_wdata;
                    if (req_trap) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'h0;
                    end else begin
                        dm_addr_d = req_addr[ADDR_W-1:2];
                        dm_wbit_d = lane_mask(req_off, req_k1);
                        dm_we_d   = req_we;
                        dm_din_d  = keep_bytes(req_wdata, req_k1);
                    end
                end
            end
            StAcc1: begin
                part_d = acc1_bytes;
                if (split_q) begin
                    dm_addr_d = dm_addr_q + AddrOne;
                    dm_wbit_d = lane_mask(2'b00, k2);
                    dm_we_d   = we_q;
                    dm_din_d  = keep_bytes(wdata_q >> {k1_q, 3'b000}, k2);
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? 32'h0 : extend(acc1_bytes, n_q, sgn_q);
                end
            end
            StAcc2: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = we_q ? 32'h0 : extend(part_q | acc2_bytes, n_q, sgn_q);
            end
            default: ;
        endcase
    end

    // Output and context registers; reset clears any write in flight at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q        <= 1'b0;
            sgn_q       <= 1'b0;
            off_q       <= 2'b00;
            n_q         <= 3'd0;
            k1_q        <= 3'd0;
            split_q     <= 1'b0;
            wdata_q     <= 32'h0;
            part_q      <= 32'h0;
            dm_addr_q   <= '0;
            dm_din_q    <= 32'h0;
            dm_we_q     <= 1'b0;
            dm_wbit_q   <= 4'b0000;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            we_q        <= we_d;
            sgn_q       <= sgn_d;
            off_q       <= off_d;
            n_q         <= n_d;
            k1_q        <= k1_d;
            split_q     <= split_d;
            wdata_q     <= wdata_d;
            part_q      <= part_d;
            dm_addr_q   <= dm_addr_d;
            dm_din_q    <= dm_din_d;
            dm_we_q     <= dm_we_d;
            dm_wbit_q   <= dm_wbit_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign dm_addr   = dm_addr_q;
    assign dm_din    = dm_din_q;
    assign dm_we     = dm_we_q;
    assign dm_wbit   = dm_wbit_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu_align.sv
// Scoreboard bench for lsu_align with a behavioural dm_4k model.
module tb_lsu_align;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [9:0]  dm_addr;
    logic [31:0] dm_din;
    logic        dm_we;
    logic [3:0]  dm_wbit;
    logic [31:0] dm_dout;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } rsp_t;

    typedef struct {
        logic [9:0]  addr;
        logic [3:0]  wbit;
        logic        we;
        logic [31:0] din;
    } acc_t;

    rsp_t exp_rsp[$];
    acc_t exp_acc[$];
    int   acc_cyc[$];

    logic [31:0] mem [1024];

    lsu_align #(.ADDR_W(12)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .dm_addr    (dm_addr),
        .dm_din     (dm_din),
        .dm_we      (dm_we),
        .dm_wbit    (dm_wbit),
        .dm_dout    (dm_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // dm_4k model: lowest enabled lane takes dm_din[7:0], next lane the next byte.
    assign dm_dout = mem[dm_addr];
    always @(posedge clk) begin
        int k;
        if (dm_we) begin
            k = 0;
            for (int l = 0; l < 4; l++) begin
                if (dm_wbit[l]) begin
                    mem[dm_addr][8*l +: 8] <= dm_din[8*k +: 8];
                    k++;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic exp_access(input logic [9:0] a, input logic [3:0] wb, input logic we,
                              input logic [31:0] din);
        acc_t e;
        e.addr = a;
        e.wbit = wb;
        e.we   = we;
        e.din  = din;
        exp_acc.push_back(e);
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic err, input int lat,
                         input bit push_rsp);
        rsp_t r;
        bit   ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: req_ready stayed 0 for 20 cycles, expected 1");
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        if (push_rsp) begin
            r.rdata = rdata;
            r.err   = err;
            r.lat   = lat;
            exp_rsp.push_back(r);
        end
        @(posedge clk);
        #1;
        if (push_rsp) acc_cyc.push_back(cyc);
        req_valid = 1'b0;
    endtask

    // Monitor: checks every memory access cycle and every response against the queues.
    always @(negedge clk) begin
        acc_t a;
        rsp_t r;
        int   c;
        if (rst_n) begin
            if (dm_we || dm_wbit != 4'b0000) begin
                if (exp_acc.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_access: addr 0x%03h wbit %b we %0b, expected none",
                             dm_addr, dm_wbit, dm_we);
                end else begin
                    a = exp_acc.pop_front();
                    chk("acc_addr", 32'(dm_addr), 32'(a.addr));
                    chk("acc_wbit", 32'(dm_wbit), 32'(a.wbit));
                    chk("acc_we", 32'(dm_we), 32'(a.we));
                    if (a.we) chk("acc_din", dm_din, a.din);
                end
            end
            if (rsp_valid) begin
                if (exp_rsp.size() == 0 || acc_cyc.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rsp: rdata 0x%08h err %0b, expected none",
                             rsp_rdata, rsp_err);
                end else begin
                    r = exp_rsp.pop_front();
                    c = acc_cyc.pop_front();
                    chk("rsp_rdata", rsp_rdata, r.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(r.err));
                    chk("rsp_latency", 32'(cyc - c + 1), 32'(r.lat));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

        // Reset values.
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        chk("rst_dm_we", 32'(dm_we), 32'h0);
        chk("rst_dm_wbit", 32'(dm_wbit), 32'h0);
        chk("rst_dm_addr", 32'(dm_addr), 32'h0);
        chk("rst_dm_din", dm_din, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Aligned word store and signed load.
        exp_access(10'h004, 4'b1111, 1'b1, 32'h12345678);
        issue(1'b1, 2'b10, 1'b0, 32'h010, 32'h12345678, 32'h0, 1'b0, 2, 1'b1);
        exp_access(10'h004, 4'b1111, 1'b0, 32'h0);
        issue(1'b0, 2'b10, 1'b1, 32'h010, 32'h0, 32'h12345678, 1'b0, 2, 1'b1);

        // Byte store at lane 3, signed and unsigned loads.
        exp_access(10'h040, 4'b1000, 1'b1, 32'h000000AB);
        issue(1'b1, 2'b00, 1'b0, 32'h103, 32'h000000AB, 32'h0, 1'b0, 2, 1'b1);
        exp_access(10'h040, 4'b1000, 1'b0, 32'h0);
        issue(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'hFFFFFFAB, 1'b0, 2, 1'b1);
        exp_access(10'h040, 4'b1000, 1'b0, 32'h0);
        issue(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h000000AB, 1'b0, 2, 1'b1);

        // Half store in upper lanes, signed and unsigned loads.
        exp_access(10'h001, 4'b1100, 1'b1, 32'h0000BEEF);
        issue(1'b1, 2'b01, 1'b0, 32'h006, 32'h0000BEEF, 32'h0, 1'b0, 2, 1'b1);
        exp_access(10'h001, 4'b1100, 1'b0, 32'h0);
        issue(1'b0, 2'b01, 1'b1, 32'h006, 32'h0, 32'hFFFFBEEF, 1'b0, 2, 1'b1);
        exp_access(10'h001, 4'b1100, 1'b0, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 32'h006, 32'h0, 32'h0000BEEF, 1'b0, 2, 1'b1);

`ifdef LSU_MISALIGN_TRAP_EN
        // Misaligned word load and odd half store trap with no access.
        issue(1'b0, 2'b10, 1'b1, 32'h002, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        issue(1'b1, 2'b01, 1'b0, 32'h005, 32'h00001234, 32'h0, 1'b1, 1, 1'b1);
        exp_access(10'h001, 4'b1111, 1'b0, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h004, 32'h0, 32'hBEEF0000, 1'b0, 2, 1'b1);
`else
        // Split word store and loads that cross the word boundary.
        exp_access(10'h002, 4'b1100, 1'b1, 32'h00003344);
        exp_access(10'h003, 4'b0011, 1'b1, 32'h00001122);
        issue(1'b1, 2'b10, 1'b0, 32'h00A, 32'h11223344, 32'h0, 1'b0, 3, 1'b1);
        exp_access(10'h002, 4'b1100, 1'b0, 32'h0);
        exp_access(10'h003, 4'b0011, 1'b0, 32'h0);
        issue(1'b0, 2'b10, 1'b1, 32'h00A, 32'h0, 32'h11223344, 1'b0, 3, 1'b1);
        exp_access(10'h002, 4'b1000, 1'b0, 32'h0);
        exp_access(10'h003, 4'b0001, 1'b0, 32'h0);
        issue(1'b0, 2'b01, 1'b1, 32'h00B, 32'h0, 32'h00002233, 1'b0, 3, 1'b1);
        exp_access(10'h003, 4'b0010, 1'b0, 32'h0);
        issue(1'b0, 2'b00, 1'b1, 32'h00D, 32'h0, 32'h00000011, 1'b0, 2, 1'b1);

        // Split half at the top of memory wraps to word 0; upper address bits ignored.
        exp_access(10'h3FF, 4'b1000, 1'b1, 32'h000000FE);
        exp_access(10'h000, 4'b0001, 1'b1, 32'h000000CA);
        issue(1'b1, 2'b01, 1'b0, 32'h00000FFF, 32'h0000CAFE, 32'h0, 1'b0, 3, 1'b1);
        exp_access(10'h3FF, 4'b1000, 1'b0, 32'h0);
        exp_access(10'h000, 4'b0001, 1'b0, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 32'hABCD0FFF, 32'h0, 32'h0000CAFE, 1'b0, 3, 1'b1);
        exp_access(10'h3FF, 4'b1000, 1'b0, 32'h0);
        exp_access(10'h000, 4'b0001, 1'b0, 32'h0);
        issue(1'b0, 2'b01, 1'b1, 32'h00000FFF, 32'h0, 32'hFFFFCAFE, 1'b0, 3, 1'b1);

        // Reset during ACC1 of a split store: write drops at once, no ACC2, no response.
        exp_access(10'h083, 4'b1100, 1'b1, 32'h00007788);
        issue(1'b1, 2'b10, 1'b0, 32'h20E, 32'h55667788, 32'h0, 1'b0, 3, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_dm_we", 32'(dm_we), 32'h0);
        chk("midrst_dm_wbit", 32'(dm_wbit), 32'h0);
        chk("midrst_req_ready", 32'(req_ready), 32'h1);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        exp_access(10'h084, 4'b1111, 1'b0, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h210, 32'h0, 32'h00000000, 1'b0, 2, 1'b1);
`endif

        repeat (10) @(negedge clk);
        chk("rsp_queue_drained", 32'(exp_rsp.size()), 32'h0);
        chk("acc_queue_drained", 32'(exp_acc.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
